// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and constants for the boot instruction memory.
package boot_pkg;
  typedef enum logic [1:0] {LOAD = 2'd0, FILL = 2'd1, RUN = 2'd2, ERROR = 2'd3} state_t;
  localparam int ADDR_W_DEF = 10;
  localparam logic [31:0] NOP_WORD = 32'h68000000;
endpackage

// File: rtl/boot_imem_if.sv
// boot_imem_if: flash-load stream, fetch port and status of the boot instruction memory.
interface boot_imem_if #(parameter int ADDR_W = boot_pkg::ADDR_W_DEF, parameter int DATA_W = 32);
  logic [DATA_W-1:0] ld_instruction;
  logic [31:0]       ld_addr;
  logic              ld_we;
  logic              prg_mode;
  logic              fetch_en;
  logic [31:0]       fetch_pc;
  logic [DATA_W-1:0] fetch_instr;
  logic              cpu_run;
  logic [ADDR_W:0]   load_count;
  logic              load_err;
  modport master(output ld_instruction, ld_addr, ld_we, prg_mode, fetch_en, fetch_pc,
                 input fetch_instr, cpu_run, load_count, load_err);
  modport slave(input ld_instruction, ld_addr, ld_we, prg_mode, fetch_en, fetch_pc,
                output fetch_instr, cpu_run, load_count, load_err);
endinterface

// File: rtl/imem_ram.sv
// imem_ram: simple dual-port RAM, synchronous write and registered read.
module imem_ram #(parameter int ADDR_W = 10, parameter int DATA_W = 32) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/boot_imem.sv
// boot_imem: captures the flash boot stream, NOP-fills the tail, then serves fetches.
module boot_imem #(
  parameter int              ADDR_W   = boot_pkg::ADDR_W_DEF,
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = boot_pkg::NOP_WORD
) (
  input logic         clk,
  input logic         reset,
  boot_imem_if.slave  bus
);
  import boot_pkg::*;
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  state_t state, state_nx;
  logic ld_we_q, prg_q, sel_q;
  logic [ADDR_W:0] load_count, fill_ptr;
  logic we, re, we_ev, prg_rise, ld_ok, fill_done, pc_ok;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata, rdata;
  assign we_ev     = bus.ld_we & ~ld_we_q;
  assign prg_rise  = bus.prg_mode & ~prg_q;
  // a sequential address below a saturated count is necessarily in range
  assign ld_ok     = (bus.ld_addr == 32'(load_count)) && (load_count != FULL);
  assign fill_done = fill_ptr >= FULL - 1'b1;
  assign pc_ok     = bus.fetch_pc < 32'(DEPTH);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= LOAD;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == LOAD) ? ((we_ev && !ld_ok) ? ERROR : prg_rise ? FILL : LOAD) :
               (state == FILL && fill_done) ? RUN : state;
  end
  always_comb begin
    we    = (state == LOAD) ? (we_ev && ld_ok) : (state == FILL) && (fill_ptr != FULL);
    waddr = (state == LOAD) ? bus.ld_addr[ADDR_W-1:0] : fill_ptr[ADDR_W-1:0];
    wdata = (state == LOAD) ? bus.ld_instruction : NOP_WORD;
    re    = (state == RUN) && bus.fetch_en && pc_ok;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ld_we_q    <= 1'b0;
      prg_q      <= 1'b0;
      load_count <= '0;
      fill_ptr   <= '0;
      sel_q      <= 1'b0;
    end else begin
      ld_we_q <= bus.ld_we;
      prg_q   <= bus.prg_mode;
      // fill_ptr shadows the post-write count so fill starts right after the last loaded word
      if (state == LOAD) begin
        load_count <= load_count + (ADDR_W+1)'(we);
        fill_ptr   <= load_count + (ADDR_W+1)'(we);
      end else if (we) fill_ptr <= fill_ptr + 1'b1;
      if (state == RUN && bus.fetch_en) sel_q <= pc_ok;
    end
  imem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(bus.fetch_pc[ADDR_W-1:0]), .rdata(rdata)
  );
  assign bus.fetch_instr = sel_q ? rdata : NOP_WORD;
  assign bus.cpu_run     = state == RUN;
  assign bus.load_err    = state == ERROR;
  assign bus.load_count  = load_count;
endmodule

// File: tb/tb_boot_imem.sv
// tb_boot_imem: random and directed boot sequences checked every cycle against a behavioural model.
module tb_boot_imem;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] NOP = 32'h68000000;
  logic clk = 0, reset = 0, reset_s = 0;
  int n_chk = 0, n_err = 0;
  int k;
  always #5 clk = ~clk;
  boot_imem_if #(.ADDR_W(AW)) bi();
  boot_imem_if #(.ADDR_W(2)) si();
  boot_imem #(.ADDR_W(AW)) dut(.clk(clk), .reset(reset), .bus(bi));
  boot_imem #(.ADDR_W(2)) dut_s(.clk(clk), .reset(reset_s), .bus(si));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // phase: 0 loading, 1 filling, 2 running, 3 error
  int ph, m_count, m_fp;
  logic [31:0] m_out;
  logic m_wep, m_prp;
  logic [31:0] m_mem [DEPTH];

  task automatic m_reset();
    ph = 0; m_count = 0; m_fp = 0; m_out = NOP; m_wep = 0; m_prp = 0;
  endtask

  task automatic m_step();
    logic wev, pr;
    wev = bi.ld_we && !m_wep;
    pr  = bi.prg_mode && !m_prp;
    m_wep = bi.ld_we;
    m_prp = bi.prg_mode;
    if (ph == 0) begin
      if (wev) begin
        if (bi.ld_addr >= DEPTH || bi.ld_addr != m_count) ph = 3;
        else begin
          m_mem[bi.ld_addr[AW-1:0]] = bi.ld_instruction;
          m_count++;
        end
      end
      if (ph == 0 && pr) begin ph = 1; m_fp = m_count; end
    end else if (ph == 1) begin
      if (m_fp < DEPTH) begin m_mem[m_fp] = NOP; m_fp++; end
      if (m_fp == DEPTH) ph = 2;
    end else if (ph == 2 && bi.fetch_en)
      m_out = (bi.fetch_pc < DEPTH) ? m_mem[bi.fetch_pc[AW-1:0]] : NOP;
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) m_reset();
    chk("cpu_run", bi.cpu_run, ph == 2);
    chk("load_err", bi.load_err, ph == 3);
    chk("load_count", bi.load_count, m_count);
    chk("fetch_instr", bi.fetch_instr, m_out);
    if (reset) m_step();
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic prg);
    tick(1);
    reset = 0; bi.ld_we = 0; bi.prg_mode = prg; bi.fetch_en = 0;
    tick(2);
    reset = 1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int hold);
    bi.ld_addr = a; bi.ld_instruction = d; bi.ld_we = 1;
    tick(hold);
    bi.ld_we = 0;
    tick(1);
  endtask

  task automatic wait_run(output int cyc);
    cyc = 0;
    while (!bi.cpu_run && cyc < DEPTH + 20) begin tick(1); cyc++; end
    chk("reach_run", bi.cpu_run, 1);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input string nm);
    bi.fetch_pc = pc; bi.fetch_en = 1;
    tick(1);
    bi.fetch_en = 0;
    chk(nm, bi.fetch_instr, exp);
  endtask

  initial begin
    bi.ld_instruction = 0; bi.ld_addr = 0; bi.ld_we = 0; bi.prg_mode = 0; bi.fetch_en = 0; bi.fetch_pc = 0;
    si.ld_instruction = 0; si.ld_addr = 0; si.ld_we = 0; si.prg_mode = 0; si.fetch_en = 0; si.fetch_pc = 0;
    do_reset(0);
    chk("rst_run", bi.cpu_run, 0);
    chk("rst_count", bi.load_count, 0);
    chk("rst_err", bi.load_err, 0);
    chk("rst_fetch", bi.fetch_instr, NOP);
    // normal boot
    for (int i = 0; i < 4; i++) wr(i, 32'hA0000001 + i, 3);
    chk("boot_count", bi.load_count, 4);
    bi.prg_mode = 1;
    wait_run(k);
    chk("boot_fill_cycles", k - 1, DEPTH - 4);
    fetch(2, 32'hA0000003, "fetch_pc2");
    fetch(10, NOP, "fetch_pc10");
    fetch(32'h400, NOP, "fetch_oob");
    fetch(0, 32'hA0000001, "fetch_pc0");
    bi.fetch_pc = 3;
    tick(3);
    chk("fetch_hold", bi.fetch_instr, 32'hA0000001);
    bi.prg_mode = 0;
    wr(0, 32'h0000DEAD, 1);
    chk("run_sticky", bi.cpu_run, 1);
    fetch(0, 32'hA0000001, "run_ignores_load");
    // held strobe
    do_reset(0);
    bi.ld_addr = 0; bi.ld_instruction = 32'hB0000000; bi.ld_we = 1;
    tick(40);
    bi.ld_we = 0;
    tick(1);
    chk("held_count", bi.load_count, 1);
    wr(1, 32'hB0000001, 2);
    chk("held_next_count", bi.load_count, 2);
    bi.prg_mode = 1;
    wait_run(k);
    fetch(0, 32'hB0000000, "held_pc0");
    fetch(1, 32'hB0000001, "held_pc1");
    fetch(2, NOP, "held_pc2");
    // sequencing error
    do_reset(0);
    wr(0, 32'hC0000000, 1);
    wr(2, 32'hC0000001, 1);
    chk("seq_err", bi.load_err, 1);
    chk("seq_count", bi.load_count, 1);
    bi.prg_mode = 1; bi.fetch_en = 1; bi.fetch_pc = 0;
    tick(5);
    chk("seq_no_run", bi.cpu_run, 0);
    chk("seq_fetch", bi.fetch_instr, NOP);
    bi.fetch_en = 0;
    // write event and prg_mode rise together
    do_reset(0);
    for (int i = 0; i < 5; i++) wr(i, 32'hD0000000 + i, 2);
    bi.ld_addr = 5; bi.ld_instruction = 32'hD0000005; bi.ld_we = 1; bi.prg_mode = 1;
    tick(1);
    bi.ld_we = 0;
    chk("simul_count", bi.load_count, 6);
    wait_run(k);
    chk("simul_fill_cycles", k, DEPTH - 6);
    fetch(5, 32'hD0000005, "simul_pc5");
    fetch(6, NOP, "simul_pc6");
    // reset during fill
    do_reset(0);
    for (int i = 0; i < 3; i++) wr(i, 32'hE0000000 + i, 1);
    bi.prg_mode = 1;
    tick(20);
    reset = 0;
    #1;
    chk("midfill_run", bi.cpu_run, 0);
    chk("midfill_count", bi.load_count, 0);
    chk("midfill_fetch", bi.fetch_instr, NOP);
    tick(2);
    bi.prg_mode = 0;
    reset = 1;
    wr(0, 32'hF0000000, 2);
    wr(1, 32'hF0000001, 2);
    bi.prg_mode = 1;
    wait_run(k);
    fetch(0, 32'hF0000000, "refill_pc0");
    fetch(1, 32'hF0000001, "refill_pc1");
    fetch(2, NOP, "refill_pc2");
    fetch(500, NOP, "refill_pc500");
    fetch(DEPTH - 1, NOP, "refill_last");
    // randomized boots, model checks every cycle
    for (int it = 0; it < 8; it++) begin
      logic pk, bad;
      int n;
      pk = ($urandom_range(0, 3) == 0);
      do_reset(pk);
      n = pk ? 0 : $urandom_range(0, 8);
      bad = !pk && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) wr(i, $urandom, $urandom_range(1, 4));
      if (bad) wr($urandom_range(0, 1) ? 32'(n + $urandom_range(1, 3)) : 32'h10000000 + $urandom_range(0, 99), $urandom, 1);
      bi.prg_mode = 1;
      if (bad) begin
        tick(10);
        chk("rand_err", bi.load_err, 1);
      end else begin
        wait_run(k);
        for (int c = 0; c < 40; c++) begin
          bi.fetch_en = $urandom_range(0, 1);
          bi.fetch_pc = ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(0, 12);
          bi.ld_we = $urandom_range(0, 1);
          bi.ld_addr = $urandom_range(0, 12);
          bi.prg_mode = $urandom_range(0, 1);
          tick(1);
        end
        bi.fetch_en = 0; bi.ld_we = 0;
      end
    end
    // full image on a four-word build
    tick(1);
    reset_s = 1;
    for (int i = 0; i < 4; i++) begin
      si.ld_addr = i; si.ld_instruction = 32'h70 + i; si.ld_we = 1;
      tick(1);
      si.ld_we = 0;
      tick(1);
    end
    chk("full_count", si.load_count, 4);
    chk("full_no_err", si.load_err, 0);
    si.prg_mode = 1;
    tick(1);
    chk("full_fill_cycle", si.cpu_run, 0);
    tick(1);
    chk("full_run", si.cpu_run, 1);
    si.fetch_pc = 3; si.fetch_en = 1;
    tick(1);
    chk("full_pc3", si.fetch_instr, 32'h73);
    si.fetch_pc = 4;
    tick(1);
    chk("full_pc4", si.fetch_instr, NOP);
    si.fetch_en = 0; si.prg_mode = 0;
    reset_s = 0;
    tick(2);
    chk("full_rst_count", si.load_count, 0);
    reset_s = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("full_count_before", si.load_count, 4);
      si.ld_addr = i; si.ld_instruction = 32'h80 + i; si.ld_we = 1;
      tick(1);
      si.ld_we = 0;
      tick(1);
    end
    chk("full_overflow_err", si.load_err, 1);
    chk("full_overflow_count", si.load_count, 4);
    chk("full_overflow_run", si.cpu_run, 0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
